muldiv_unit: RTL and testbench

Multi-cycle RV32M/RV64M execution unit sitting beside the ALU in the EX stage. It is parametrised on XLEN and executes all eight M-extension operations selected by func3. It uses an iterative radix-2 divider and either a single-cycle or an iterative multiplier. A valid/ready handshake lets the hazard unit stall the pipeline until the result is ready. A one-entry quotient/remainder cache lets a DIV/REM pair on identical operands finish in one cycle.

---
 rtl/muldiv_unit_pkg.sv | 37 +++
 rtl/muldiv_unit_radix2_div_core.sv | 39 +++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the M-extension multiply/divide unit.
// Holds the func3 operation codes, the FSM state encoding, the
// result-source tag, and the operand-signedness decoders.
package muldiv_unit_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Where the DONE-state result comes from.
  typedef enum logic [1:0] {
    SRC_MUL  = 2'd0,
    SRC_DIV  = 2'd1,
    SRC_SPEC = 2'd2
  } src_e;

  function automatic logic signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_radix2_div_core.sv
// Unsigned restoring radix-2 divider, one quotient bit per step.
// Ports: clk; i_load captures dividend/divisor; i_step performs one
// iteration; o_quot/o_rem are valid after XLEN steps.
// The {rem, quot} register is 2*XLEN+1 bits: rem in the top XLEN+1.
module radix2_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            i_load,
  input  logic            i_step,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem
);

  logic [2*XLEN:0] r_acc;
  logic [XLEN-1:0] r_dvsr;
  logic [XLEN+1:0] w_trial;
  logic            w_fit;

  // Shifted partial remainder (rem field plus next dividend bit) minus divisor.
  assign w_trial = r_acc[2*XLEN:XLEN-1] - {2'b00, r_dvsr};
  assign w_fit   = ~w_trial[XLEN+1];

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_acc  <= {{(XLEN+1){1'b0}}, i_dividend};
      r_dvsr <= i_divisor;
    end else if (i_step) begin
      r_acc <= {(w_fit ? w_trial[XLEN:0] : r_acc[2*XLEN-1:XLEN-1]),
                r_acc[XLEN-2:0], w_fit};
    end
  end

  assign o_quot = r_acc[XLEN-1:0];
  assign o_rem  = r_acc[2*XLEN-1:XLEN];

endmodule

// File: rtl/muldiv_unit.sv
// RV32M/RV64M multiply/divide execution unit.
// Ports: clk, rst_n (async active-low); in_valid/in_ready accept
// handshake with func3/rs1/rs2 operands; flush kills any op in flight;
// out_valid pulses one cycle with result (zero otherwise); busy is high
// whenever the FSM is not IDLE and stalls the pipeline.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int MUL_ITERATIVE = 0,
  parameter int DIV_CACHE_EN  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int              CW       = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return (~v) + XLEN'(1);
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v);
    return (~v) + (2*XLEN)'(1);
  endfunction

  state_e r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;

  logic [2:0]      r_f3;
  logic            r_neg_a, r_neg_b;
  src_e            r_src;
  logic [XLEN-1:0] r_a, r_b, r_spec, r_mcand;
  logic [2*XLEN:0] r_mul;

  logic            r_c_vld, r_c_sgn;
  logic [XLEN-1:0] r_c_a, r_c_b, r_c_quot, r_c_rem;

  logic            w_accept, w_is_div, w_is_rem, w_dsgn;
  logic            w_neg_a, w_neg_b, w_div0, w_ovf, w_hit, w_shortcut;
  logic [XLEN-1:0] w_abs_a, w_abs_b, w_spec_val;
  logic [2*XLEN-1:0] w_prod_fast, w_prod_s;
  logic [XLEN:0]   w_mul_add;
  logic [XLEN-1:0] w_quot, w_rem, w_quot_s, w_rem_s, w_res;

  // Accept-side operand decode
  assign in_ready   = (r_state == ST_IDLE);
  assign w_accept   = in_valid && in_ready && !flush;
  assign w_is_div   = func3[2];
  assign w_is_rem   = func3[1];
  assign w_dsgn     = !func3[0];
  assign w_neg_a    = signed_a(func3) && rs1[XLEN-1];
  assign w_neg_b    = signed_b(func3) && rs2[XLEN-1];
  assign w_abs_a    = w_neg_a ? neg_x(rs1) : rs1;
  assign w_abs_b    = w_neg_b ? neg_x(rs2) : rs2;
  assign w_div0     = (rs2 == '0);
  assign w_ovf      = w_dsgn && (rs1 == MIN_NEG) && (rs2 == '1);
  assign w_hit      = (DIV_CACHE_EN != 0) && r_c_vld && (rs1 == r_c_a) &&
                      (rs2 == r_c_b) && (w_dsgn == r_c_sgn);
  assign w_shortcut = w_div0 || w_ovf || w_hit;
  assign w_prod_fast = {{XLEN{1'b0}}, w_abs_a} * {{XLEN{1'b0}}, w_abs_b};

  always_comb begin
    w_spec_val = w_is_rem ? r_c_rem : r_c_quot;
    if (w_div0)     w_spec_val = w_is_rem ? rs1 : '1;
    else if (w_ovf) w_spec_val = w_is_rem ? '0 : rs1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!w_is_div)       w_state_nxt = (MUL_ITERATIVE != 0) ? ST_MUL : ST_DONE;
          else if (w_shortcut) w_state_nxt = ST_DONE;
          else                 w_state_nxt = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: begin
        if (flush)                   w_state_nxt = ST_IDLE;
        else if (r_cnt == CW'(1))    w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_c_vld <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && ((w_state_nxt == ST_MUL) || (w_state_nxt == ST_DIV)))
        r_cnt <= CNT_LOAD;
      else if ((r_state == ST_MUL) || (r_state == ST_DIV))
        r_cnt <= flush ? '0 : r_cnt - CW'(1);
      if ((r_state == ST_DONE) && (r_src == SRC_DIV))
        r_c_vld <= 1'b1;
    end
  end

  // Iterative shift-add: add multiplicand when the multiplier LSB is set, shift right.
  assign w_mul_add = r_mul[2*XLEN:XLEN] + (r_mul[0] ? {1'b0, r_mcand} : '0);

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_f3    <= func3;
      r_a     <= rs1;
      r_b     <= rs2;
      r_neg_a <= w_neg_a;
      r_neg_b <= w_neg_b;
      r_spec  <= w_spec_val;
      r_mcand <= w_abs_a;
      r_src   <= !w_is_div ? SRC_MUL : (w_shortcut ? SRC_SPEC : SRC_DIV);
      r_mul   <= (MUL_ITERATIVE != 0) ? {{(XLEN+1){1'b0}}, w_abs_b} : {1'b0, w_prod_fast};
    end else if (r_state == ST_MUL) begin
      r_mul <= {1'b0, w_mul_add, r_mul[XLEN-1:1]};
    end
    if ((r_state == ST_DONE) && (r_src == SRC_DIV)) begin
      r_c_a    <= r_a;
      r_c_b    <= r_b;
      r_c_sgn  <= !r_f3[0];
      r_c_quot <= w_quot_s;
      r_c_rem  <= w_rem_s;
    end
  end

  radix2_div_core #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .i_load     (w_accept && w_is_div),
    .i_step     (r_state == ST_DIV),
    .i_dividend (w_abs_a),
    .i_divisor  (w_abs_b),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  // DONE: sign correction and result select
  assign w_prod_s = (r_neg_a ^ r_neg_b) ? neg_2x(r_mul[2*XLEN-1:0]) : r_mul[2*XLEN-1:0];
  assign w_quot_s = (r_neg_a ^ r_neg_b) ? neg_x(w_quot) : w_quot;
  assign w_rem_s  = r_neg_a ? neg_x(w_rem) : w_rem;

  always_comb begin
    w_res = r_spec;
    case (r_src)
      SRC_MUL: w_res = (r_f3 == F3_MUL) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
      SRC_DIV: w_res = r_f3[1] ? w_rem_s : w_quot_s;
      default: w_res = r_spec;
    endcase
  end

  assign out_valid = (r_state == ST_DONE) && !flush;
  assign result    = out_valid ? w_res : '0;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a single-cycle-multiply instance and an
// iterative-multiply instance share one stimulus stream; results and
// latencies are compared against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk, rst_n, in_valid, flush;
  logic [2:0]  func3;
  logic [31:0] rs1, rs2;
  logic        rdy_f, ov_f, busy_f, rdy_i, ov_i, busy_i;
  logic [31:0] res_f, res_i;

  int checks = 0;
  int failures = 0;

  bit          m_cvld = 0;
  bit          m_csgn = 0;
  logic [31:0] m_ca = 0, m_cb = 0;

  muldiv_unit #(.XLEN(32), .MUL_ITERATIVE(0), .DIV_CACHE_EN(1)) u_fast (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_f),
    .func3(func3), .rs1(rs1), .rs2(rs2), .flush(flush),
    .out_valid(ov_f), .result(res_f), .busy(busy_f));

  muldiv_unit #(.XLEN(32), .MUL_ITERATIVE(1), .DIV_CACHE_EN(1)) u_iter (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_i),
    .func3(func3), .rs1(rs1), .rs2(rs2), .flush(flush),
    .out_valid(ov_i), .result(res_i), .busy(busy_i));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    p = '0;
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res);
    int lat_f, lat_i, cnt_f, cnt_i, exp_lf, exp_li;
    logic [31:0] got_f, got_i;
    bit is_div, special, hit;
    is_div  = f3[2];
    special = is_div && (b == 0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    hit     = is_div && !special && m_cvld && a == m_ca && b == m_cb && (!f3[0]) == m_csgn;
    exp_lf  = (is_div && !special && !hit) ? 33 : 1;
    exp_li  = (!is_div || (!special && !hit)) ? 33 : 1;
    lat_f = 0; lat_i = 0; cnt_f = 0; cnt_i = 0;
    got_f = 32'hDEADBEEF; got_i = 32'hDEADBEEF;
    @(negedge clk);
    func3 = f3; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (ov_f) begin cnt_f++; if (lat_f == 0) begin lat_f = k; got_f = res_f; end end
      if (ov_i) begin cnt_i++; if (lat_i == 0) begin lat_i = k; got_i = res_i; end end
      if (k == 1 && !ov_i) begin
        checks++;
        if (res_i !== 32'd0 || busy_i !== 1'b1) begin
          failures++;
          $display("FAIL %s idle_out: iter result=%h busy=%b, required result=0 busy=1", name, res_i, busy_i);
        end
      end
      if (lat_f != 0 && lat_i != 0 && k > lat_f && k > lat_i) break;
    end
    checks++;
    if (lat_f != exp_lf) begin failures++; $display("FAIL %s fast_latency: got %0d required %0d", name, lat_f, exp_lf); end
    checks++;
    if (lat_i != exp_li) begin failures++; $display("FAIL %s iter_latency: got %0d required %0d", name, lat_i, exp_li); end
    checks++;
    if (got_f !== exp_res) begin failures++; $display("FAIL %s fast_result: got %h required %h", name, got_f, exp_res); end
    checks++;
    if (got_i !== exp_res) begin failures++; $display("FAIL %s iter_result: got %h required %h", name, got_i, exp_res); end
    checks++;
    if (cnt_f != 1 || cnt_i != 1) begin
      failures++;
      $display("FAIL %s pulse_width: fast=%0d iter=%0d cycles, required 1", name, cnt_f, cnt_i);
    end
    if (is_div && !special && !hit) begin
      m_cvld = 1; m_ca = a; m_cb = b; m_csgn = !f3[0];
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_cvld = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (rdy_f !== 1 || ov_f !== 0 || busy_f !== 0 || res_f !== 0 ||
        rdy_i !== 1 || ov_i !== 0 || busy_i !== 0 || res_i !== 0) begin
      failures++;
      $display("FAIL reset_state: fast rdy/ov/busy/res=%b%b%b/%h iter=%b%b%b/%h required 100/0",
               rdy_f, ov_f, busy_f, res_f, rdy_i, ov_i, busy_i, res_i);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mul_directed();
    run_op("mulh_min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000);
    run_op("mulhu_max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("mulhsu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("mul_6x7",    3'd0, 32'd6, 32'd7, 32'd42);
  endtask

  task automatic test_div_directed();
    run_op("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
    run_op("rem_m7_3", 3'd6, 32'hFFFFFFF9, 32'd3, 32'hFFFFFFFF);
  endtask

  task automatic test_special();
    run_op("divu_by0", 3'd5, 32'd100, 32'd0, 32'hFFFFFFFF);
    run_op("remu_by0", 3'd7, 32'd100, 32'd0, 32'd100);
    run_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0);
  endtask

  task automatic test_cache();
    run_op("cache_div",   3'd4, 32'd100, 32'd7, 32'd14);
    run_op("cache_rem",   3'd6, 32'd100, 32'd7, 32'd2);
    run_op("cache_remu",  3'd7, 32'd100, 32'd7, 32'd2);
    do_reset();
    run_op("cache_after_rst", 3'd7, 32'd100, 32'd7, 32'd2);
  endtask

  task automatic test_flush();
    int seen;
    seen = 0;
    @(negedge clk);
    func3 = 3'd4; rs1 = 32'd1000; rs2 = 32'd13; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 1; k < 10; k++) begin
      if (ov_f || ov_i) seen++;
      if (k == 9) begin @(negedge clk); flush = 1'b1; end
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    checks++;
    if (rdy_f !== 1 || rdy_i !== 1 || busy_f !== 0 || busy_i !== 0) begin
      failures++;
      $display("FAIL flush_ready: rdy=%b%b busy=%b%b required rdy=11 busy=00", rdy_f, rdy_i, busy_f, busy_i);
    end
    for (int k = 0; k < 40; k++) begin
      if (ov_f || ov_i) seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL flush_no_valid: out_valid seen %0d cycles required 0", seen); end
    run_op("div_after_flush", 3'd4, 32'd9, 32'd3, 32'd3);
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    func3 = 3'd5; rs1 = 32'd55; rs2 = 32'd5; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (busy_f !== 0 || busy_i !== 0) begin
      failures++;
      $display("FAIL flush_idle: busy=%b%b required 00", busy_f, busy_i);
    end
  endtask

  task automatic test_mid_mul_reset();
    @(negedge clk);
    func3 = 3'd3; rs1 = 32'h12345678; rs2 = 32'h9ABCDEF0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (busy_i !== 1) begin failures++; $display("FAIL mid_mul_busy: busy=%b required 1", busy_i); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy_i !== 0 || rdy_i !== 1 || ov_i !== 0 || res_i !== 0) begin
      failures++;
      $display("FAIL async_reset: busy=%b rdy=%b ov=%b res=%h required 0/1/0/0", busy_i, rdy_i, ov_i, res_i);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_cvld = 0;
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b, la, lb;
    int mode;
    la = 32'd77; lb = 32'd5;
    for (int n = 0; n < 40; n++) begin
      f3   = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 6);
      a = $urandom; b = $urandom;
      case (mode)
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin
          a = 32'($urandom_range(0, 300));
          b = 32'($urandom_range(1, 20));
          if ($urandom_range(0, 1) == 1) a = ~a + 32'd1;
          if ($urandom_range(0, 1) == 1) b = ~b + 32'd1;
        end
        3, 4: begin a = la; b = lb; end
        default: ;
      endcase
      la = a; lb = b;
      run_op("random", f3, a, b, ref_result(f3, a, b));
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    func3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
    test_reset();
    test_mul_directed();
    test_div_directed();
    test_special();
    test_cache();
    test_flush();
    test_flush_idle();
    test_mid_mul_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
